// File: rtl/rv32i_types.sv
// Shared types for the instruction fetch slice.
//   fetch_entry_t  : one instruction-queue entry {pc, inst}
//   fetch_state_t  : request/stale control states of fetch_unit
//   IMEM_RMASK_*   : read-mask encodings for the instruction memory port
package rv32i_types;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT       = 2'd1,
        WAIT_STALE = 2'd2
    } fetch_state_t;

    localparam logic [3:0]  IMEM_RMASK_WORD = 4'hF;
    localparam logic [3:0]  IMEM_RMASK_NONE = 4'h0;
    localparam logic [31:0] INST_BYTES      = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue between fetch and decode.
// Circular buffer of DEPTH fetch_entry_t entries (DEPTH a power of two,
// so the pointers wrap naturally).
//   clk, rst    : clock, asynchronous active-high reset (pointers/count)
//   enq         : write enq_data at the tail (ignored when full or flushing)
//   enq_data    : entry to write
//   deq         : pop the head (ignored when empty or flushing)
//   flush       : discard every entry; wins over enq and deq
//   head        : current head entry, forced to zero while empty
//   count       : number of valid entries (0..DEPTH)
//   empty, full : count == 0 / count == DEPTH
module fetch_fifo
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq,
    input  fetch_entry_t               enq_data,
    input  logic                       deq,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_enq;
    logic             do_deq;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign do_enq = enq && !full && !flush;
    assign do_deq = deq && !empty && !flush;

    // Gating the head with empty keeps the outputs at zero after reset
    // without having to clear the storage array.
    assign head = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_enq) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (do_deq) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem[wptr] <= enq_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word read at a time to instruction
// memory, queues the returned words for decode, and handles redirects from
// downstream, including responses that belong to a request issued before
// the redirect (stale responses).
//   clk, rst               : clock, asynchronous active-high reset
//   imem_addr, imem_rmask  : read request (rmask 4'hF for the whole request)
//   imem_rdata, imem_resp  : one-cycle read response
//   redirect, redirect_pc  : flush the queue and refetch from redirect_pc
//   deq_ready              : decode takes the head entry this cycle
//   deq_valid, deq_pc,
//   deq_inst, deq_order    : head entry of the instruction queue and its
//                            sequence number
module fetch_unit
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        deq_ready,
    output logic        deq_valid,
    output logic [31:0] deq_pc,
    output logic [31:0] deq_inst,
    output logic [63:0] deq_order
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [31:0]      pc_q;      // address of the next request to issue
    logic [31:0]      addr_q;    // address of the request in flight
    logic [63:0]      order_q;
    logic             issue;
    logic             accept;
    logic             deq_fire;
    fetch_entry_t     enq_entry;
    fetch_entry_t     fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;

    // Request control. A request occupies WAIT (or WAIT_STALE once a
    // redirect has orphaned it) up to and including its response cycle,
    // so at most one is ever outstanding. Issue is decided only in IDLE,
    // which also guarantees a full queue never receives a response.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                // No issue in the redirect cycle: pc_q still holds the old
                // stream and the new target only lands at this edge.
                if (!redirect && (fifo_count < CNT_W'(DEPTH))) begin
                    issue      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp) begin
                    accept     = !redirect && !fifo_full;
                    state_next = IDLE;
                end else if (redirect) begin
                    state_next = WAIT_STALE;
                end
            end
            WAIT_STALE: begin
                // The response belongs to the flushed stream; drop it.
                if (imem_resp) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign deq_fire = deq_valid && deq_ready && !redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            order_q <= '0;
        end else begin
            state <= state_next;
            if (redirect) begin
                pc_q <= redirect_pc;
            end else if (issue) begin
                pc_q <= pc_q + INST_BYTES;
            end
            // addr_q is only reloaded on issue, so a stale request keeps
            // presenting its original address until its response.
            if (issue) begin
                addr_q <= pc_q;
            end
            if (deq_fire) begin
                order_q <= order_q + 64'd1;
            end
        end
    end

    assign enq_entry = '{pc: addr_q, inst: imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .enq      (accept),
        .enq_data (enq_entry),
        .deq      (deq_fire),
        .flush    (redirect),
        .head     (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign imem_rmask = (state == IDLE) ? IMEM_RMASK_NONE : IMEM_RMASK_WORD;
    assign imem_addr  = addr_q;
    assign deq_valid  = !fifo_empty;
    assign deq_pc     = fifo_head.pc;
    assign deq_inst   = fifo_head.inst;
    assign deq_order  = order_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h1eceb000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata = 32'hdeadbeef;
    logic        imem_resp = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        deq_ready = 1'b0;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_inst;
    logic [63:0] deq_order;

    fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rmask  (imem_rmask),
        .imem_rdata  (imem_rdata),
        .imem_resp   (imem_resp),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .deq_ready   (deq_ready),
        .deq_valid   (deq_valid),
        .deq_pc      (deq_pc),
        .deq_inst    (deq_inst),
        .deq_order   (deq_order)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // stimulus knobs
    int          lat = 1;
    bit          rdy = 1'b0;
    bit          redir = 1'b0;
    logic [31:0] redir_target = 32'h0;

    // memory model
    bit          m_pend = 1'b0;
    bit          m_killed = 1'b0;
    int          m_rem = 0;
    logic [31:0] m_addr = 32'h0;

    // reference model / scoreboard
    ent_t        sb[$];
    logic [31:0] exp_pc = RESET_PC;
    logic [63:0] exp_order = 64'd0;
    logic [31:0] req_log[$];
    logic [31:0] dpc_log[$];
    logic [63:0] dord_log[$];
    int          n_push = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    // One clock cycle: check outputs, run memory, apply redirect/ready, update model.
    task automatic step();
        bit   resp_now;
        bit   resp_killed;
        ent_t e;
        @(negedge clk);
        resp_now    = 1'b0;
        resp_killed = 1'b0;
        checks++;
        if (deq_valid !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL deq_valid: got %b want %b", deq_valid, (sb.size() != 0));
        end
        checks++;
        if (deq_order !== exp_order) begin
            errors++;
            $display("FAIL deq_order: got %0d want %0d", deq_order, exp_order);
        end
        if (sb.size() != 0) begin
            checks++;
            if (deq_pc !== sb[0].pc || deq_inst !== sb[0].inst) begin
                errors++;
                $display("FAIL deq_entry: got %h/%h want %h/%h", deq_pc, deq_inst, sb[0].pc, sb[0].inst);
            end
        end
        imem_resp  = 1'b0;
        imem_rdata = 32'hdeadbeef;
        if (m_pend) begin
            checks++;
            if (imem_rmask !== 4'hF || imem_addr !== m_addr) begin
                errors++;
                $display("FAIL req_hold: got %h@%h want f@%h", imem_rmask, imem_addr, m_addr);
            end
            m_rem--;
            if (m_rem <= 0) begin
                imem_resp   = 1'b1;
                imem_rdata  = inst_of(m_addr);
                m_pend      = 1'b0;
                resp_now    = 1'b1;
                resp_killed = m_killed;
            end
        end else if (imem_rmask !== 4'h0) begin
            checks++;
            if (imem_rmask !== 4'hF || imem_addr !== exp_pc) begin
                errors++;
                $display("FAIL req_addr: got %h@%h want f@%h", imem_rmask, imem_addr, exp_pc);
            end
            req_log.push_back(imem_addr);
            m_addr   = imem_addr;
            exp_pc   = exp_pc + 32'd4;
            m_pend   = 1'b1;
            m_rem    = lat;
            m_killed = 1'b0;
        end
        redirect    = redir;
        redirect_pc = redir_target;
        if (redir) begin
            exp_pc = redir_target;
            sb.delete();
            if (m_pend) m_killed = 1'b1;
            if (resp_now) resp_killed = 1'b1;
        end
        deq_ready = rdy;
        if (sb.size() != 0 && rdy && !redir) begin
            dpc_log.push_back(deq_pc);
            dord_log.push_back(deq_order);
            void'(sb.pop_front());
            exp_order = exp_order + 64'd1;
        end
        if (resp_now && !resp_killed) begin
            e.pc   = m_addr;
            e.inst = inst_of(m_addr);
            sb.push_back(e);
            n_push++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0; redirect_pc = 32'h0; deq_ready = 1'b0;
        imem_resp = 1'b0; imem_rdata = 32'hdeadbeef;
        rdy = 1'b0; redir = 1'b0; lat = 1;
        m_pend = 1'b0; m_killed = 1'b0; m_rem = 0;
        sb.delete(); req_log.delete(); dpc_log.delete(); dord_log.delete();
        exp_pc = RESET_PC; exp_order = 64'd0; n_push = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (imem_rmask !== 4'h0 || imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_imem: got %h@%h want 0@%h", imem_rmask, imem_addr, RESET_PC);
        end
        checks++;
        if (deq_valid !== 1'b0 || deq_pc !== 32'h0 || deq_inst !== 32'h0 || deq_order !== 64'd0) begin
            errors++;
            $display("FAIL reset_deq: got %b %h %h %0d want 0 0 0 0", deq_valid, deq_pc, deq_inst, deq_order);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        checks++;
        if (req_log.size() != 1 || imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_issue: got %0d reqs addr %h want 1 at %h", req_log.size(), imem_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] want;
        do_reset();
        rdy = 1'b1; lat = 1;
        for (int i = 0; i < 60 && dord_log.size() < 3; i++) step();
        checks++;
        if (dord_log.size() < 3) begin
            errors++;
            $display("FAIL seq_timeout: got %0d deqs want 3", dord_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                want = RESET_PC + 32'(4 * i);
                checks++;
                if (req_log[i] !== want || dpc_log[i] !== want || dord_log[i] !== 64'(i)) begin
                    errors++;
                    $display("FAIL seq_%0d: got req %h pc %h ord %0d want %h %h %0d",
                             i, req_log[i], dpc_log[i], dord_log[i], want, want, i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rdy = 1'b0; lat = 1;
        repeat (40) step();
        checks++;
        if (n_push != 4) begin
            errors++;
            $display("FAIL bp_fill: got %0d responses want 4", n_push);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (imem_rmask !== 4'h0) begin
                errors++;
                $display("FAIL bp_idle: got rmask %h want 0", imem_rmask);
            end
        end
        rdy = 1'b1;
        for (int i = 0; i < 20 && req_log.size() < 5; i++) step();
        checks++;
        if (req_log.size() < 5) begin
            errors++;
            $display("FAIL bp_resume: got %0d reqs want 5", req_log.size());
        end else if (req_log[4] !== 32'h1eceb010) begin
            errors++;
            $display("FAIL bp_resume: got %h want 1eceb010", req_log[4]);
        end
        for (int i = 0; i < 40 && dord_log.size() < 5; i++) step();
        checks++;
        if (dord_log.size() < 5 || dpc_log[dpc_log.size()-1] !== 32'h1eceb010) begin
            errors++;
            $display("FAIL bp_drain: got %0d deqs want 5 ending at 1eceb010", dord_log.size());
        end
    endtask

    task automatic test_redirect_outstanding();
        int base_req;
        int base_deq;
        do_reset();
        rdy = 1'b1; lat = 3;
        for (int i = 0; i < 40 && !(req_log.size() >= 2 && m_pend && m_rem == 3); i++) step();
        base_req = req_log.size();
        base_deq = dord_log.size();
        redir = 1'b1; redir_target = 32'h1eceb100;
        step();
        redir = 1'b0;
        for (int i = 0; i < 40 && dord_log.size() <= base_deq; i++) step();
        checks++;
        if (req_log.size() <= base_req || req_log[base_req] !== 32'h1eceb100) begin
            errors++;
            $display("FAIL redir_addr: got %0d reqs want next at 1eceb100", req_log.size() - base_req);
        end
        checks++;
        if (dord_log.size() <= base_deq) begin
            errors++;
            $display("FAIL redir_deq: got no dequeue want 1eceb100");
        end else if (dpc_log[base_deq] !== 32'h1eceb100 || dord_log[base_deq] !== 64'(base_deq)) begin
            errors++;
            $display("FAIL redir_deq: got %h ord %0d want 1eceb100 ord %0d",
                     dpc_log[base_deq], dord_log[base_deq], base_deq);
        end
    endtask

    task automatic test_redirect_stale();
        int base_req;
        int base_deq;
        do_reset();
        rdy = 1'b1; lat = 4;
        for (int i = 0; i < 40 && !(req_log.size() >= 1 && m_pend && m_rem == 4); i++) step();
        base_req = req_log.size();
        base_deq = dord_log.size();
        redir = 1'b1; redir_target = 32'h1eceb200;
        step();
        redir_target = 32'h1eceb300;
        step();
        redir = 1'b0;
        for (int i = 0; i < 40 && dord_log.size() <= base_deq; i++) step();
        checks++;
        if (req_log.size() <= base_req || req_log[base_req] !== 32'h1eceb300) begin
            errors++;
            $display("FAIL stale_addr: got %0d reqs want next at 1eceb300", req_log.size() - base_req);
        end
        checks++;
        if (dord_log.size() <= base_deq || dpc_log[base_deq] !== 32'h1eceb300) begin
            errors++;
            $display("FAIL stale_deq: got %0d deqs want first at 1eceb300", dord_log.size() - base_deq);
        end
    endtask

    task automatic test_redirect_on_resp();
        do_reset();
        rdy = 1'b0; lat = 1;
        for (int i = 0; i < 40 && !(n_push >= 2 && m_pend && m_rem == 1); i++) step();
        redir = 1'b1; rdy = 1'b1; redir_target = 32'h1eceb400;
        step();
        redir = 1'b0;
        step();
        checks++;
        if (deq_valid !== 1'b0 || deq_order !== 64'd0) begin
            errors++;
            $display("FAIL resp_redir: got valid %b ord %0d want 0 0", deq_valid, deq_order);
        end
        for (int i = 0; i < 30 && dord_log.size() < 1; i++) step();
        checks++;
        if (dord_log.size() < 1 || dpc_log[0] !== 32'h1eceb400 || dord_log[0] !== 64'd0) begin
            errors++;
            $display("FAIL resp_redir_deq: got %0d deqs want first 1eceb400 ord 0", dord_log.size());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        rdy = 1'b1; lat = 3;
        for (int i = 0; i < 60 && !(dord_log.size() >= 1 && m_pend); i++) step();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (imem_rmask !== 4'h0 || imem_addr !== RESET_PC || deq_valid !== 1'b0 || deq_order !== 64'd0) begin
            errors++;
            $display("FAIL async_rst: got %h@%h v%b ord %0d want 0@%h v0 ord 0",
                     imem_rmask, imem_addr, deq_valid, deq_order, RESET_PC);
        end
        do_reset();
        rdy = 1'b1;
        for (int i = 0; i < 30 && dord_log.size() < 1; i++) step();
        checks++;
        if (req_log.size() < 1 || dord_log.size() < 1 || req_log[0] !== RESET_PC ||
            dpc_log[0] !== RESET_PC || dord_log[0] !== 64'd0) begin
            errors++;
            $display("FAIL async_restart: got %0d deqs want first %h ord 0", dord_log.size(), RESET_PC);
        end
    endtask

    task automatic test_wrap();
        int base;
        do_reset();
        rdy = 1'b1; lat = 1;
        repeat (5) step();
        base = dord_log.size();
        redir = 1'b1; redir_target = 32'hfffffff8;
        step();
        redir = 1'b0;
        for (int i = 0; i < 60 && dord_log.size() < base + 3; i++) step();
        checks++;
        if (dord_log.size() < base + 3 || dpc_log[base + 2] !== 32'h00000000) begin
            errors++;
            $display("FAIL pc_wrap: got %0d deqs want third at 00000000", dord_log.size() - base);
        end
    endtask

    task automatic test_back_to_back();
        int deq_before;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            lat          = $urandom_range(1, 3);
            rdy          = ($urandom_range(0, 3) != 0);
            redir        = ($urandom_range(0, 24) == 0);
            redir_target = $urandom() & 32'hffff_fffc;
            step();
        end
        redir = 1'b0; rdy = 1'b1;
        deq_before = dord_log.size();
        repeat (40) step();
        checks++;
        if (dord_log.size() <= deq_before) begin
            errors++;
            $display("FAIL b2b_progress: got %0d deqs want more than 0", dord_log.size() - deq_before);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_stale();
        test_redirect_on_resp();
        test_async_reset();
        test_wrap();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning instruction-queue entries (power of two, at least 2).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h1eceb000, meaning the first fetch address after reset.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state changes on posedge clk.
REQ-004 The block SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-005 The block SHALL have port imem_addr  output  32  meaning the fetch address, 4-byte aligned.
REQ-006 The block SHALL have port imem_rmask  output  4  meaning the read request (4'hF requesting, 4'h0 idle).
REQ-007 The block SHALL have port imem_rdata  input  32  meaning the instruction word, valid only when imem_resp=1.
REQ-008 The block SHALL have port imem_resp  input  1  meaning the one-cycle response strobe.
REQ-009 The block SHALL have port redirect  input  1  meaning a taken-branch or jump flush from downstream.
REQ-010 The block SHALL have port redirect_pc  input  32  meaning the new fetch target, sampled when redirect=1.
REQ-011 The block SHALL have port deq_ready  input  1  meaning decode accepts the head entry this cycle.
REQ-012 The block SHALL have port deq_valid  output  1  meaning the head entry is valid.
REQ-013 The block SHALL have ports deq_pc  output  32  and deq_inst  output  32  meaning the head entry's PC and instruction.
REQ-014 The block SHALL have port deq_order  output  64  meaning the sequence number of the head entry for RVFI.

Function
REQ-015 The block SHALL keep at most one imem request outstanding; a request is the interval from issue through the imem_resp cycle, inclusive.
REQ-016 During a request, the block SHALL hold imem_rmask=4'hF and hold imem_addr stable at the fetch PC.
REQ-017 The block SHALL issue a request only when no request is outstanding, no stale response is pending, and queue count < DEPTH, counted before this cycle's dequeue.
REQ-018 Back-to-back fetch: the earliest next issue SHALL be the cycle after imem_resp; on that issue, PC increments by 4 (32-bit wrap).
REQ-019 On a non-stale imem_resp, the block SHALL enqueue {pc, imem_rdata}; deq_valid SHALL rise the cycle after imem_resp when the queue was empty.
REQ-020 deq_valid SHALL equal (count != 0); deq_pc, deq_inst and deq_order SHALL come directly from registers, with no combinational path from any input.
REQ-021 A dequeue SHALL occur iff deq_valid && deq_ready && !redirect; on each dequeue, deq_order SHALL increment by 1.
REQ-022 A simultaneous enqueue and dequeue SHALL leave count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-023 On redirect, the block SHALL, in the same cycle: empty the queue, set fetch PC to redirect_pc, and drop any imem_resp arriving that cycle.
REQ-024 On redirect while a request is outstanding and not responding that cycle, the block SHALL set stale; the next imem_resp SHALL be discarded and SHALL clear stale.
REQ-025 When stale is set, imem_rmask and imem_addr SHALL be held for the old request until its response.
REQ-026 The first request to redirect_pc SHALL issue no earlier than the cycle after redirect, and no earlier than the cycle after the stale response.
REQ-027 deq_order SHALL NOT rewind on redirect.
REQ-028 When redirect arrives while stale is already set, the block SHALL update PC only.

Reset
REQ-029 While rst=1, outputs SHALL be: imem_rmask=0, imem_addr=RESET_PC, deq_valid=0, deq_pc=0, deq_inst=0, deq_order=0.
REQ-030 While rst=1, internal state SHALL be: count=0, pointers=0, outstanding=0, stale=0.
REQ-031 The first request SHALL issue in the first clock edge after rst deasserts.
REQ-032 rst asserted mid-request SHALL abandon the request with no stale tracking; the memory model is reset together with the block.

Structure
REQ-033 The rv32i_types package SHALL hold fetch_entry_t {pc[31:0], inst[31:0]}.
REQ-034 The queue SHALL be sub-module fetch_fifo (parameter DEPTH).
REQ-035 fetch_fifo SHALL have ports: enq, enq_data, deq, flush, head, count, empty, full.
REQ-036 The request/stale control SHALL stay in fetch_unit as a three-state FSM: IDLE, WAIT, WAIT_STALE.

Verification
REQ-037 Reset release with 1-cycle memory latency -> addresses 1eceb000, 1eceb004, 1eceb008 issued; deq_valid one cycle after each resp; deq_order 0,1,2.
REQ-038 deq_ready=0 with DEPTH=4 -> exactly 4 responses enqueued and rmask stays 0 afterward; deq_ready=1 -> fetch resumes at 1eceb010.
REQ-039 Redirect to 0x1eceb100 while a 3-cycle request is outstanding -> old response dropped; next imem_addr=1eceb100; first deq_pc=1eceb100.
REQ-040 Redirect in the same cycle as imem_resp and deq_ready -> no dequeue and no enqueue; count=0 next cycle.
REQ-041 rst asserted mid-request -> rmask=0 immediately (asynchronous); after release, fetch restarts at RESET_PC with order 0.
